// File: rtl/ship_pkg.sv
// Shared constants, state encoding and position helper for the player ship.
package ship_pkg;

  // Ship life-cycle states, shared with anything that decodes ship status.
  typedef enum logic [1:0] {
    ALIVE   = 2'd0,
    DEAD    = 2'd1,
    RESPAWN = 2'd2,
    OVER    = 2'd3
  } ship_state_t;

  // Sprite and screen geometry, also used by the ship draw stage.
  localparam int SHIP_W    = 48;
  localparam int SHIP_H    = 64;
  localparam int SHIP_YPOS = 680;
  localparam int SCREEN_W  = 1024;

  // One frame of horizontal motion with saturation at both edges.
  // The left-edge compare happens before the subtraction so the 11-bit
  // value can never wrap below xmin.
  function automatic logic [10:0] step_x(
    input logic [10:0] x,
    input logic        mv_left,
    input logic        mv_right,
    input logic [10:0] spd,
    input logic [10:0] xmin,
    input logic [10:0] xmax
  );
    logic [10:0] res;
    res = x;
    if (mv_left && !mv_right) begin
      res = (x < xmin + spd) ? xmin : x - spd;
    end else if (mv_right && !mv_left) begin
      res = (x > xmax - spd) ? xmax : x + spd;
    end
    return res;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Vertical-blank rising-edge detector producing a one-cycle frame tick.
// Reused by every per-frame controller (ship, enemies, bullets).
module frame_tick (
  input  logic pclk,
  input  logic rst_n,
  input  logic vblnk_in,
  output logic tick
);

  logic vblnk_d_reg;

  // Delay vblank by one cycle so its rising edge can be detected.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_d_reg <= 1'b0;
    end else begin
      vblnk_d_reg <= vblnk_in;
    end
  end

  assign tick = vblnk_in & ~vblnk_d_reg;

endmodule

// File: rtl/ship_ctl.sv
// Player ship controller: frame-synchronous x motion and the
// alive / dead / respawn-blink / game-over life cycle.
module ship_ctl
  import ship_pkg::*;
#(
  parameter int XMIN           = 0,
  parameter int XMAX           = SCREEN_W - SHIP_W,
  parameter int START_X        = 488,
  parameter int SPEED          = 4,
  parameter int LIVES          = 3,
  parameter int DEAD_FRAMES    = 60,
  parameter int RESPAWN_FRAMES = 120,
  parameter int BLINK_LOG2     = 3
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        vblnk_in,
  input  logic        left,
  input  logic        right,
  input  logic        hit,
  input  logic        restart,
  output logic [10:0] xpos,
  output logic        dead_ship,
  output logic [3:0]  lives,
  output logic        invuln,
  output logic        game_over
);

  localparam logic [10:0] XMIN_C  = 11'(XMIN);
  localparam logic [10:0] XMAX_C  = 11'(XMAX);
  localparam logic [10:0] START_C = 11'(START_X);
  localparam logic [10:0] SPEED_C = 11'(SPEED);
  localparam logic [3:0]  LIVES_C = 4'(LIVES);
  localparam logic [7:0]  DEAD_LAST    = 8'(DEAD_FRAMES - 1);
  localparam logic [7:0]  RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);

  logic        tick;
  ship_state_t state_reg, state_next;
  logic [10:0] xpos_reg, xpos_next;
  logic [3:0]  lives_reg, lives_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        dead_ship_reg, dead_ship_next;
  logic        invuln_reg, invuln_next;
  logic        game_over_reg, game_over_next;

  frame_tick u_frame_tick (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .vblnk_in (vblnk_in),
    .tick     (tick)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ALIVE;
      xpos_reg      <= START_C;
      lives_reg     <= LIVES_C;
      cnt_reg       <= 8'd0;
      dead_ship_reg <= 1'b0;
      invuln_reg    <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      xpos_reg      <= xpos_next;
      lives_reg     <= lives_next;
      cnt_reg       <= cnt_next;
      dead_ship_reg <= dead_ship_next;
      invuln_reg    <= invuln_next;
      game_over_reg <= game_over_next;
    end
  end

  // Next-state, position, lives, frame counter, and output decode of the
  // upcoming state so every output is registered with one cycle of latency.
  always_comb begin
    state_next     = state_reg;
    xpos_next      = xpos_reg;
    lives_next     = lives_reg;
    cnt_next       = cnt_reg;
    dead_ship_next = 1'b0;
    invuln_next    = 1'b0;
    game_over_next = 1'b0;

    if (restart) begin
      // Restart wins over hit and tick arriving in the same cycle.
      state_next = ALIVE;
      lives_next = LIVES_C;
      xpos_next  = START_C;
      cnt_next   = 8'd0;
    end else begin
      case (state_reg)
        ALIVE: begin
          if (hit) begin
            // A hit freezes the ship where it was struck.
            state_next = DEAD;
            lives_next = lives_reg - 4'd1;
            cnt_next   = 8'd0;
          end else if (tick) begin
            xpos_next = step_x(xpos_reg, left, right, SPEED_C, XMIN_C, XMAX_C);
          end
        end
        DEAD: begin
          if (tick) begin
            if (cnt_reg == DEAD_LAST) begin
              if (lives_reg == 4'd0) begin
                state_next = OVER;
              end else begin
                state_next = RESPAWN;
                xpos_next  = START_C;
                cnt_next   = 8'd0;
              end
            end else begin
              cnt_next = cnt_reg + 8'd1;
            end
          end
        end
        RESPAWN: begin
          // Hits are ignored here; the player may still steer.
          if (tick) begin
            xpos_next = step_x(xpos_reg, left, right, SPEED_C, XMIN_C, XMAX_C);
            if (cnt_reg == RESPAWN_LAST) begin
              state_next = ALIVE;
              cnt_next   = 8'd0;
            end else begin
              cnt_next = cnt_reg + 8'd1;
            end
          end
        end
        OVER: begin
          state_next = OVER;
        end
        default: begin
          state_next = ALIVE;
        end
      endcase
    end

    case (state_next)
      DEAD: begin
        dead_ship_next = 1'b1;
      end
      RESPAWN: begin
        invuln_next    = 1'b1;
        dead_ship_next = cnt_next[BLINK_LOG2];
      end
      OVER: begin
        dead_ship_next = 1'b1;
        game_over_next = 1'b1;
      end
      default: begin
        dead_ship_next = 1'b0;
      end
    endcase
  end

  assign xpos      = xpos_reg;
  assign lives     = lives_reg;
  assign dead_ship = dead_ship_reg;
  assign invuln    = invuln_reg;
  assign game_over = game_over_reg;

endmodule

// File: tb/tb_ship_ctl.sv
// Bench for ship_ctl: directed scenarios plus random traffic, all checked
// every cycle against a frame-count model of the ship life cycle.
module tb_ship_ctl;

  logic        pclk;
  logic        rst_n;
  logic        vblnk_in;
  logic        left;
  logic        right;
  logic        hit;
  logic        restart;
  logic [10:0] xpos;
  logic        dead_ship;
  logic [3:0]  lives;
  logic        invuln;
  logic        game_over;

  int total = 0;
  int bad   = 0;

  // Model state: m_since = ticks since the last death (-1 while alive).
  int m_x, m_lives, m_since, m_over, m_vprev;

  ship_ctl dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .vblnk_in  (vblnk_in),
    .left      (left),
    .right     (right),
    .hit       (hit),
    .restart   (restart),
    .xpos      (xpos),
    .dead_ship (dead_ship),
    .lives     (lives),
    .invuln    (invuln),
    .game_over (game_over)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int clampx(input int v);
    if (v < 0) return 0;
    if (v > 976) return 976;
    return v;
  endfunction

  function automatic int move(input int x, input logic l, input logic r);
    if (l && !r) return clampx(x - 4);
    if (r && !l) return clampx(x + 4);
    return x;
  endfunction

  function automatic int exp_dead();
    if (m_over != 0) return 1;
    if (m_since < 0) return 0;
    if (m_since < 60) return 1;
    return ((m_since - 60) / 8) % 2;
  endfunction

  function automatic int exp_invuln();
    return (m_over == 0 && m_since >= 60) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_x = 488; m_lives = 3; m_since = -1; m_over = 0; m_vprev = 0;
  endtask

  // Compare process: check outputs against the model, then advance the
  // model with the inputs the DUT will sample at the next rising edge.
  initial begin
    model_reset();
    forever begin
      @(negedge pclk);
      if (!rst_n) model_reset();
      chk("xpos", int'(xpos), m_x);
      chk("lives", int'(lives), m_lives);
      chk("dead_ship", int'(dead_ship), exp_dead());
      chk("invuln", int'(invuln), exp_invuln());
      chk("game_over", int'(game_over), m_over);
      if (rst_n) begin
        bit tk;
        tk = vblnk_in && (m_vprev == 0);
        m_vprev = vblnk_in ? 1 : 0;
        if (restart) begin
          m_x = 488; m_lives = 3; m_since = -1; m_over = 0;
        end else if (m_over != 0) begin
          // frozen until restart
        end else if (m_since < 0) begin
          if (hit) begin
            m_lives = m_lives - 1;
            m_since = 0;
          end else if (tk) begin
            m_x = move(m_x, left, right);
          end
        end else if (m_since < 60) begin
          if (tk) begin
            m_since++;
            if (m_since == 60) begin
              if (m_lives == 0) m_over = 1;
              else m_x = 488;
            end
          end
        end else begin
          if (tk) begin
            m_x = move(m_x, left, right);
            m_since++;
            if (m_since == 180) m_since = -1;
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic frame(input logic l, input logic r);
    left = l; right = r; vblnk_in = 1'b1;
    cyc(1);
    vblnk_in = 1'b0;
    cyc(2);
  endtask

  task automatic frames(input int n, input logic l, input logic r);
    for (int i = 0; i < n; i++) frame(l, r);
  endtask

  task automatic rand_frames(input int n);
    for (int i = 0; i < n; i++) frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    cyc(1);
    hit = 1'b0;
  endtask

  // Directed scenarios, then random traffic.
  initial begin
    int saved_x;
    rst_n = 1'b0; vblnk_in = 1'b0; left = 1'b0; right = 1'b0;
    hit = 1'b0; restart = 1'b0;
    cyc(3);
    chk("rst_xpos", int'(xpos), 488);
    chk("rst_lives", int'(lives), 3);
    chk("rst_dead", int'(dead_ship), 0);
    chk("rst_invuln", int'(invuln), 0);
    chk("rst_over", int'(game_over), 0);
    rst_n = 1'b1;
    cyc(2);

    frame(1'b0, 1'b1); chk("right1", int'(xpos), 492);
    frame(1'b0, 1'b1); chk("right2", int'(xpos), 496);
    frame(1'b0, 1'b1); chk("right3", int'(xpos), 500);
    frames(2, 1'b1, 1'b1); chk("both_hold", int'(xpos), 500);
    frames(130, 1'b0, 1'b1); chk("right_sat", int'(xpos), 976);
    frame(1'b0, 1'b1); chk("right_sat2", int'(xpos), 976);
    frames(243, 1'b1, 1'b0); chk("left_at4", int'(xpos), 4);
    frame(1'b1, 1'b0); chk("left_to0", int'(xpos), 0);
    frame(1'b1, 1'b0); chk("left_sat", int'(xpos), 0);

    pulse_hit();
    chk("hit_dead", int'(dead_ship), 1);
    chk("hit_lives", int'(lives), 2);
    frames(60, 1'b0, 1'b0);
    chk("respawn_x", int'(xpos), 488);
    chk("respawn_inv", int'(invuln), 1);
    chk("blink_lo", int'(dead_ship), 0);
    frames(8, 1'b0, 1'b0);
    chk("blink_hi", int'(dead_ship), 1);
    pulse_hit();
    chk("resp_hit_lives", int'(lives), 2);
    chk("resp_hit_inv", int'(invuln), 1);
    rand_frames(112);
    chk("alive_inv", int'(invuln), 0);
    chk("alive_dead", int'(dead_ship), 0);

    saved_x = m_x;
    left = 1'b0; right = 1'b1; vblnk_in = 1'b1; hit = 1'b1;
    cyc(1);
    hit = 1'b0; vblnk_in = 1'b0;
    chk("hit_tick_x", int'(xpos), saved_x);
    chk("hit_tick_lives", int'(lives), 1);
    cyc(2);
    rand_frames(180);
    pulse_hit();
    chk("third_lives", int'(lives), 0);
    frames(60, 1'b0, 1'b0);
    chk("over_flag", int'(game_over), 1);
    chk("over_dead", int'(dead_ship), 1);
    chk("over_lives", int'(lives), 0);
    rand_frames(3);
    pulse_hit();
    chk("over_hold", int'(game_over), 1);

    restart = 1'b1; cyc(1); restart = 1'b0;
    chk("restart_lives", int'(lives), 3);
    chk("restart_x", int'(xpos), 488);
    chk("restart_over", int'(game_over), 0);

    pulse_hit();
    frames(10, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_x", int'(xpos), 488);
    chk("async_lives", int'(lives), 3);
    chk("async_dead", int'(dead_ship), 0);
    cyc(2);
    rst_n = 1'b1;
    frames(2, 1'b1, 1'b0);
    pulse_hit();
    restart = 1'b1; hit = 1'b1;
    cyc(1);
    restart = 1'b0; hit = 1'b0;
    chk("rs_hit_lives", int'(lives), 3);
    chk("rs_hit_dead", int'(dead_ship), 0);
    chk("rs_hit_x", int'(xpos), 488);

    for (int i = 0; i < 4000; i++) begin
      vblnk_in = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) left = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) right = 1'($urandom_range(0, 1));
      hit = ($urandom_range(0, 149) == 0);
      restart = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    hit = 1'b0; restart = 1'b0; vblnk_in = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
